// File: rtl/snake_engine.sv
// Snake game engine on a 40x40 board: clears and seeds the board, steps the snake on a
// timer, detects wall/self collisions and places apples via a one-cycle-latency read port.
module snake_engine #(
    parameter int unsigned STEP_CYCLES = 1000000,
    parameter int unsigned MAX_LEN     = 64
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    output logic        oWE,
    output logic [10:0] oWADDR,
    output logic [31:0] oWDATA,
    output logic [10:0] oRADDR,
    input  logic [31:0] iRDATA,
    output logic        oGAME_OVER,
    output logic [7:0]  oSCORE
);
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned POS_W  = 6;
    localparam int unsigned GRID   = 40;
    localparam int unsigned CELLS  = GRID * GRID;
    localparam int unsigned CNT_W  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned PTR_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1);

    localparam logic [DATA_W-1:0] CELL_EMPTY = DATA_W'(0);
    localparam logic [DATA_W-1:0] CELL_SNAKE = DATA_W'(1);
    localparam logic [DATA_W-1:0] CELL_APPLE = DATA_W'(3);

    typedef enum logic [3:0] {
        CLEAR, INIT, RUN, READ_HEAD, CHECK, WR_HEAD, ERASE_TAIL, APPLE_RD, APPLE_CHK, DEAD
    } state_e;

    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_q, clr_d;
    logic [1:0]          init_q, init_d;
    logic [CNT_W-1:0]    step_q, step_d;
    dir_e                dir_q, dir_d, pend_q, pend_d;
    logic [POS_W-1:0]    hrow_q, hrow_d, hcol_q, hcol_d;
    logic [POS_W-1:0]    nrow_q, nrow_d, ncol_q, ncol_d;
    logic [ADDR_W-1:0]   naddr_q, naddr_d;
    logic [PTR_W-1:0]    hp_q, hp_d, tp_q, tp_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [7:0]          score_q, score_d;
    logic                ate_q, ate_d, grow_q, grow_d;
    logic [ADDR_W-1:0]   tail_addr_q, tail_addr_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d, raddr_q, raddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                over_q, over_d;

    logic [ADDR_W-1:0]   body_q [MAX_LEN];
    logic                push_c;
    logic [ADDR_W-1:0]   push_addr_c;
    logic [POS_W-1:0]    nrow_c, ncol_c;
    logic                off_grid_c;
    logic [ADDR_W-1:0]   cand_c;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [POS_W-1:0] row,
                                                    input logic [POS_W-1:0] col);
        return ADDR_W'(row) * ADDR_W'(GRID) + ADDR_W'(col);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_LEN - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign cand_c = ADDR_W'(lfsr_q % 16'(CELLS));

    // Candidate head one cell along the pending direction, flagged if it leaves the grid.
    always_comb begin
        nrow_c     = hrow_q;
        ncol_c     = hcol_q;
        off_grid_c = 1'b0;
        case (pend_q)
            DIR_UP: begin
                off_grid_c = (hrow_q == '0);
                nrow_c     = hrow_q - POS_W'(1);
            end
            DIR_DOWN: begin
                off_grid_c = (hrow_q == POS_W'(GRID - 1));
                nrow_c     = hrow_q + POS_W'(1);
            end
            DIR_LEFT: begin
                off_grid_c = (hcol_q == '0);
                ncol_c     = hcol_q - POS_W'(1);
            end
            default: begin
                off_grid_c = (hcol_q == POS_W'(GRID - 1));
                ncol_c     = hcol_q + POS_W'(1);
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        clr_d       = clr_q;
        init_d      = init_q;
        step_d      = '0;
        dir_d       = dir_q;
        pend_d      = pend_q;
        hrow_d      = hrow_q;
        hcol_d      = hcol_q;
        nrow_d      = nrow_q;
        ncol_d      = ncol_q;
        naddr_d     = naddr_q;
        hp_d        = hp_q;
        tp_d        = tp_q;
        len_d       = len_q;
        score_d     = score_q;
        ate_d       = ate_q;
        grow_d      = grow_q;
        tail_addr_d = tail_addr_q;
        lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        raddr_d     = raddr_q;
        over_d      = over_q;
        push_c      = 1'b0;
        push_addr_c = '0;

        case (state_q)
            CLEAR: begin
                we_d    = 1'b1;
                waddr_d = clr_q;
                wdata_d = CELL_EMPTY;
                if (clr_q == ADDR_W'(CELLS - 1)) begin
                    state_d = INIT;
                    init_d  = '0;
                end else begin
                    clr_d = clr_q + ADDR_W'(1);
                end
            end
            // Three body cells left to right, then the first apple.
            INIT: begin
                we_d   = 1'b1;
                init_d = init_q + 2'd1;
                if (init_q == 2'd3) begin
                    waddr_d = ADDR_W'(820);
                    wdata_d = CELL_APPLE;
                    state_d = RUN;
                end else begin
                    waddr_d     = ADDR_W'(410) + ADDR_W'(init_q);
                    wdata_d     = CELL_SNAKE;
                    push_c      = 1'b1;
                    push_addr_c = ADDR_W'(410) + ADDR_W'(init_q);
                    hp_d        = ptr_inc(hp_q);
                end
            end
            RUN: begin
                if (step_q == CNT_W'(STEP_CYCLES - 1)) begin
                    dir_d = pend_q;
                    if (off_grid_c) begin
                        state_d = DEAD;
                        over_d  = 1'b1;
                    end else begin
                        nrow_d  = nrow_c;
                        ncol_d  = ncol_c;
                        naddr_d = cell_addr(nrow_c, ncol_c);
                        raddr_d = cell_addr(nrow_c, ncol_c);
                        state_d = READ_HEAD;
                    end
                end else begin
                    step_d = step_q + CNT_W'(1);
                end
            end
            READ_HEAD: state_d = CHECK;
            // Tail address is captured before the push so a full ring cannot overwrite it.
            CHECK: begin
                tail_addr_d = body_q[tp_q];
                if (iRDATA == CELL_SNAKE) begin
                    state_d = DEAD;
                    over_d  = 1'b1;
                end else begin
                    ate_d  = (iRDATA == CELL_APPLE);
                    grow_d = 1'b0;
                    if (iRDATA == CELL_APPLE) begin
                        score_d = score_q + 8'd1;
                        if (len_q < LEN_W'(MAX_LEN)) begin
                            grow_d = 1'b1;
                            len_d  = len_q + LEN_W'(1);
                        end
                    end
                    state_d = WR_HEAD;
                end
            end
            WR_HEAD: begin
                we_d        = 1'b1;
                waddr_d     = naddr_q;
                wdata_d     = CELL_SNAKE;
                push_c      = 1'b1;
                push_addr_c = naddr_q;
                hp_d        = ptr_inc(hp_q);
                hrow_d      = nrow_q;
                hcol_d      = ncol_q;
                if (grow_q) begin
                    raddr_d = cand_c;
                    state_d = APPLE_RD;
                end else begin
                    state_d = ERASE_TAIL;
                end
            end
            ERASE_TAIL: begin
                we_d    = 1'b1;
                waddr_d = tail_addr_q;
                wdata_d = CELL_EMPTY;
                tp_d    = ptr_inc(tp_q);
                if (ate_q) begin
                    raddr_d = cand_c;
                    state_d = APPLE_RD;
                end else begin
                    state_d = RUN;
                end
            end
            APPLE_RD: state_d = APPLE_CHK;
            APPLE_CHK: begin
                if (iRDATA == CELL_EMPTY) begin
                    we_d    = 1'b1;
                    waddr_d = raddr_q;
                    wdata_d = CELL_APPLE;
                    state_d = RUN;
                end else begin
                    raddr_d = cand_c;
                    state_d = APPLE_RD;
                end
            end
            DEAD: state_d = DEAD;
            default: state_d = CLEAR;
        endcase

        // Compare against the direction in force next cycle so a same-cycle turn cannot reverse.
        if (!up) begin
            if (dir_d != DIR_DOWN) pend_d = DIR_UP;
        end else if (!down) begin
            if (dir_d != DIR_UP) pend_d = DIR_DOWN;
        end else if (!left) begin
            if (dir_d != DIR_RIGHT) pend_d = DIR_LEFT;
        end else if (!right) begin
            if (dir_d != DIR_LEFT) pend_d = DIR_RIGHT;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= CLEAR;
            clr_q       <= '0;
            init_q      <= '0;
            step_q      <= '0;
            dir_q       <= DIR_RIGHT;
            pend_q      <= DIR_RIGHT;
            hrow_q      <= POS_W'(10);
            hcol_q      <= POS_W'(12);
            nrow_q      <= '0;
            ncol_q      <= '0;
            naddr_q     <= '0;
            hp_q        <= '0;
            tp_q        <= '0;
            len_q       <= LEN_W'(3);
            score_q     <= '0;
            ate_q       <= 1'b0;
            grow_q      <= 1'b0;
            tail_addr_q <= '0;
            lfsr_q      <= 16'hACE1;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            raddr_q     <= '0;
            over_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_q       <= clr_d;
            init_q      <= init_d;
            step_q      <= step_d;
            dir_q       <= dir_d;
            pend_q      <= pend_d;
            hrow_q      <= hrow_d;
            hcol_q      <= hcol_d;
            nrow_q      <= nrow_d;
            ncol_q      <= ncol_d;
            naddr_q     <= naddr_d;
            hp_q        <= hp_d;
            tp_q        <= tp_d;
            len_q       <= len_d;
            score_q     <= score_d;
            ate_q       <= ate_d;
            grow_q      <= grow_d;
            tail_addr_q <= tail_addr_d;
            lfsr_q      <= lfsr_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            raddr_q     <= raddr_d;
            over_q      <= over_d;
        end
    end

    // Body ring of cell addresses, oldest at tp_q.
    always_ff @(posedge iCLK) begin
        if (push_c) body_q[hp_q] <= push_addr_c;
    end

    assign oWE        = we_q;
    assign oWADDR     = waddr_q;
    assign oWDATA     = wdata_q;
    assign oRADDR     = raddr_q;
    assign oGAME_OVER = over_q;
    assign oSCORE     = score_q;

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: board memory model with one-cycle read latency and a write log.
`timescale 1ns/1ps
module tb_snake_engine;
    logic        clk = 1'b0;
    logic        rst;
    logic        btn_up, btn_down, btn_left, btn_right;
    logic        we;
    logic [10:0] waddr, raddr;
    logic [31:0] wdata, rdata;
    logic        game_over;
    logic [7:0]  score;

    typedef struct {
        logic [10:0] a;
        logic [31:0] d;
        logic [31:0] old;
    } wr_t;

    logic [31:0] mem [2048];
    wr_t         wq [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    snake_engine #(.STEP_CYCLES(4), .MAX_LEN(64)) dut (
        .iCLK       (clk),
        .iRST       (rst),
        .up         (btn_up),
        .down       (btn_down),
        .left       (btn_left),
        .right      (btn_right),
        .oWE        (we),
        .oWADDR     (waddr),
        .oWDATA     (wdata),
        .oRADDR     (raddr),
        .iRDATA     (rdata),
        .oGAME_OVER (game_over),
        .oSCORE     (score)
    );

    always #5 clk = ~clk;

    // Board: log each write with the cell's previous value, then read after write.
    always @(posedge clk) begin
        if (we) begin
            wq.push_back('{a: waddr, d: wdata, old: mem[waddr]});
            mem[waddr] = wdata;
        end
        rdata <= mem[raddr];
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic next_write(output bit ok, output logic [10:0] a, output logic [31:0] d,
                              output logic [31:0] old);
        int w = 0;
        wr_t e;
        while (wq.size() == 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        ok = (wq.size() != 0);
        a = '0; d = '0; old = '0;
        if (!ok) begin
            chk("write_timeout", 32'(wq.size()), 32'd1);
        end else begin
            e = wq.pop_front();
            a = e.a; d = e.d; old = e.old;
        end
    endtask

    task automatic expect_write(input string tag, input int exp_a, input int exp_d);
        bit ok;
        logic [10:0] a;
        logic [31:0] d, old;
        next_write(ok, a, d, old);
        if (ok) begin
            chk({tag, "_addr"}, 32'(a), 32'(exp_a));
            chk({tag, "_data"}, d, 32'(exp_d));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        wq.delete();
        rst = 1'b0;
    endtask

    // Consume n clear writes, counting any that break the ascending 0-fill.
    task automatic consume_clear(input string tag, input int n);
        bit ok;
        logic [10:0] a;
        logic [31:0] d, old;
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            next_write(ok, a, d, old);
            if (!ok) break;
            if (32'(a) != 32'(i) || d != 32'd0) bad++;
        end
        chk({tag, "_clear_bad"}, 32'(bad), 32'd0);
    endtask

    task automatic consume_init(input string tag);
        consume_clear(tag, 1600);
        expect_write({tag, "_init0"}, 410, 1);
        expect_write({tag, "_init1"}, 411, 1);
        expect_write({tag, "_init2"}, 412, 1);
        expect_write({tag, "_apple0"}, 820, 3);
        chk({tag, "_over"}, 32'(game_over), 32'd0);
    endtask

    initial begin
        bit          ok;
        logic [10:0] a;
        logic [31:0] d, old;
        int          w;

        for (int i = 0; i < 2048; i++) mem[i] = 32'hDEAD;
        rst = 1'b1;
        btn_up = 1'b1; btn_down = 1'b1; btn_left = 1'b1; btn_right = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_we",    32'(we),        32'd0);
        chk("rst_waddr", 32'(waddr),     32'd0);
        chk("rst_wdata", wdata,          32'd0);
        chk("rst_raddr", 32'(raddr),     32'd0);
        chk("rst_over",  32'(game_over), 32'd0);
        chk("rst_score", 32'(score),     32'd0);
        wq.delete();
        rst = 1'b0;

        // Left held while moving right has no effect; two plain steps.
        btn_left = 1'b0;
        consume_init("p1");
        expect_write("p1_head1", 413, 1);
        expect_write("p1_tail1", 410, 0);
        expect_write("p1_head2", 414, 1);
        expect_write("p1_tail2", 411, 0);
        btn_left = 1'b1;

        // Up held: first step turns upward.
        btn_up = 1'b0;
        do_reset();
        consume_init("p2");
        expect_write("p2_head_up", 372, 1);
        expect_write("p2_tail", 410, 0);
        btn_up = 1'b1;

        // Run right into the east wall.
        do_reset();
        consume_init("p3");
        for (int k = 0; k < 27; k++) begin
            expect_write($sformatf("p3_head%0d", k), 413 + k, 1);
            expect_write($sformatf("p3_tail%0d", k), 410 + k, 0);
        end
        w = 0;
        while (!game_over && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("p3_over", 32'(game_over), 32'd1);
        repeat (20) @(negedge clk);
        chk("p3_dead_writes", 32'(wq.size()), 32'd0);
        chk("p3_dead_we", 32'(we), 32'd0);
        chk("p3_over_hold", 32'(game_over), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("p3_rst_over", 32'(game_over), 32'd0);
        repeat (2) @(negedge clk);
        wq.delete();
        rst = 1'b0;

        // Apple at the next head: score, grow without tail erase, respawn on an empty cell.
        consume_init("p4");
        chk("p4_score0", 32'(score), 32'd0);
        mem[413] = 32'd3;
        expect_write("p4_head_eat", 413, 1);
        next_write(ok, a, d, old);
        if (ok) begin
            chk("p4_apple_data", d, 32'd3);
            chk("p4_apple_was_empty", old, 32'd0);
            chk("p4_score1", 32'(score), 32'd1);
            if (a != 11'd414) begin
                expect_write("p4_head_next", 414, 1);
                expect_write("p4_tail_next", 410, 0);
            end
        end

        // Reset in the middle of the clear sweep.
        do_reset();
        consume_clear("p5", 801);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("p5_rst_score", 32'(score), 32'd0);
        chk("p5_rst_we", 32'(we), 32'd0);
        chk("p5_rst_waddr", 32'(waddr), 32'd0);
        wq.delete();
        rst = 1'b0;
        expect_write("p5_restart0", 0, 0);
        expect_write("p5_restart1", 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/snake_engine.md
SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 1000000: clock cycles between snake moves.
REQ-002 SHALL have parameter MAX_LEN, default 64: body buffer depth in cells.
REQ-003 SHALL have port iCLK, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port iRST, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports up, down, left, right, input, 1 each: active-low direction buttons.
REQ-006 SHALL have port oWE, output, 1: board write strobe, one cycle per write.
REQ-007 SHALL have port oWADDR, output, 11: board write cell index, 40*row+col, range 0..1599.
REQ-008 SHALL have port oWDATA, output, 32: cell value; 0 empty, 1 snake, 3 apple.
REQ-009 SHALL have port oRADDR, output, 11: board read cell index.
REQ-010 SHALL have port iRDATA, input, 32: board cell value at oRADDR, valid exactly one cycle after oRADDR is presented.
REQ-011 SHALL have port oGAME_OVER, output, 1: high once a collision is detected.
REQ-012 SHALL have port oSCORE, output, 8: count of apples eaten.

Function
REQ-013 SHALL use FSM states CLEAR, INIT, RUN, READ_HEAD, CHECK, WR_HEAD, ERASE_TAIL, APPLE_RD, APPLE_CHK, DEAD.
REQ-014 CLEAR SHALL write value 0 to addresses 0..1599 in ascending order, one per cycle (1600 cycles), then go to INIT.
REQ-015 INIT SHALL write value 1 to cells 410, 411, 412 (in that order), then value 3 to cell 820, then go to RUN; head=412, tail=410, length=3, direction=RIGHT.
REQ-016 Direction input SHALL be sampled every cycle with priority up>down>left>right into a pending direction; a request opposite to the current direction SHALL be ignored.
REQ-017 In RUN, a step counter SHALL count 0..STEP_CYCLES-1; on terminal count, current direction := pending direction, compute next head, go to READ_HEAD.
REQ-018 Next head off-grid (row <0 or >39, col <0 or >39) SHALL go directly to DEAD with no write.
REQ-019 READ_HEAD SHALL drive oRADDR=next head; CHECK SHALL evaluate iRDATA the following cycle.
REQ-020 iRDATA==1 (any snake cell, including current tail) SHALL go to DEAD.
REQ-021 iRDATA==3 SHALL increment oSCORE (wraps at 255) and grow: length+1, tail not erased; at length==MAX_LEN, no growth and tail erased.
REQ-022 WR_HEAD SHALL write 1 to the new head and push it into a MAX_LEN-entry circular address buffer (head pointer wraps MAX_LEN-1 -> 0).
REQ-023 ERASE_TAIL (no growth) SHALL write 0 to the oldest buffer entry and advance the tail pointer with wrap; then RUN, or APPLE_RD if an apple was eaten.
REQ-024 A free-running 16-bit LFSR (taps 16,14,13,11, nonzero seed 16'hACE1 at reset) SHALL supply apple candidates = LFSR mod 1600.
REQ-025 APPLE_RD/APPLE_CHK SHALL read the candidate; if 0, write 3 there and return to RUN; else retry with the current LFSR value.
REQ-026 oWE SHALL be high at most one cycle per write, never in RUN idle, READ_HEAD, CHECK, APPLE_RD or DEAD.
REQ-027 DEAD SHALL hold oGAME_OVER=1, issue no writes, and remain until reset.
REQ-028 The step counter SHALL be held at 0 outside RUN; step latency from terminal count to head write SHALL be 3 cycles.

Reset
REQ-029 Reset SHALL force state CLEAR, clear address 0, oWE=0, oWADDR=0, oWDATA=0, oRADDR=0, oGAME_OVER=0, oSCORE=0, step counter=0, pointers=0, length=3, direction=RIGHT.
REQ-030 Reset asserted in any state, including mid-CLEAR or DEAD, SHALL restart CLEAR from address 0 on the next cycle.

Verification
REQ-031 Reset then run -> 1600 writes of 0 to 0..1599, then 1@410, 1@411, 1@412, 3@820, oGAME_OVER=0.
REQ-032 STEP_CYCLES=4, no button -> per step write 1@413 then 0@410; next step 1@414, 0@411.
REQ-033 left asserted while moving right -> ignored; up asserted -> next head 372 (412-40).
REQ-034 Keep moving right from 412 for 27 steps to col 39, one more step -> DEAD, no write, oGAME_OVER=1.
REQ-035 Board model returns 3 at next head -> oSCORE=1, no tail erase that step, exactly one new write of 3 at an address whose model value was 0.
REQ-036 Assert iRST at CLEAR address 800 -> next write is 0@0, oSCORE=0.
